// File: rtl/bilin_pkg.sv
// Shared defaults and state encoding for the bilinear upscaler front end.
package bilin_pkg;

  localparam int DEF_DW            = 8;
  localparam int DEF_ROW_CNT_WIDTH = 12;
  localparam int DEF_COL_CNT_WIDTH = 12;
  localparam int DEF_MAX_COLS      = 1920;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    EDGE  = 3'd3,
    FLUSH = 3'd4,
    FEDGE = 3'd5
  } state_t;

  // Address width able to reach every entry of a buffer of the given depth.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/line_buf.sv
// Single-row pixel store: simple dual-port RAM, 1-cycle synchronous read.
// A read and a write to the same address in one cycle return the old value.
module line_buf
  import bilin_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_MAX_COLS,
  parameter int AW    = addr_w(DEF_MAX_COLS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Read and write are both non-blocking, so a same-address read sees the old row.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/src_window_gen.sv
// Raster pixel stream -> 2x2 source windows with right/bottom edge replication.
// One window per source pixel; calc_en lags its trigger by exactly 2 cycles.
module src_window_gen
  import bilin_pkg::*;
#(
  parameter int DW            = DEF_DW,
  parameter int ROW_CNT_WIDTH = DEF_ROW_CNT_WIDTH,
  parameter int COL_CNT_WIDTH = DEF_COL_CNT_WIDTH,
  parameter int MAX_COLS      = DEF_MAX_COLS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic [COL_CNT_WIDTH-1:0] img_width,
  input  logic [ROW_CNT_WIDTH-1:0] img_height,
  input  logic [DW-1:0]            pix_i,
  input  logic                     pix_valid_i,
  output logic                     pix_ready_o,
  output logic [DW-1:0]            buf00,
  output logic [DW-1:0]            buf10,
  output logic [DW-1:0]            buf01,
  output logic [DW-1:0]            buf11,
  output logic                     calc_en,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int AW = addr_w(MAX_COLS);

  state_t                   state, nxt_state;
  logic [COL_CNT_WIDTH-1:0] col, nxt_col, width_q, nxt_width;
  logic [ROW_CNT_WIDTH-1:0] row, nxt_row, height_q, nxt_height;
  logic                     col_last, row_last;

  // trigger-cycle event flags
  logic ram_we, ram_re;
  logic ev_emit, ev_upd, ev_edge, ev_flush, ev_last;

  // window pipeline: vld_pipe[0] = trigger registered, vld_pipe[1] = calc_en
  logic [1:0]    vld_pipe;
  logic          s1_upd, s1_edge, s1_flush, s1_last;
  logic [DW-1:0] s1_pix;
  logic [DW-1:0] ram_rdata, bot_new;
  logic [DW-1:0] cur_top, cur_bot;   // previous column of the upper/lower row

  assign col_last = (col == width_q - COL_CNT_WIDTH'(1));
  assign row_last = (row == height_q - ROW_CNT_WIDTH'(1));
  assign busy     = (state != IDLE);
  assign calc_en  = vld_pipe[1];

  line_buf #(.DW(DW), .DEPTH(MAX_COLS), .AW(AW)) u_line_buf (
    .clk   (clk),
    .we    (ram_we),
    .waddr (col[AW-1:0]),
    .wdata (pix_i),
    .re    (ram_re),
    .raddr (col[AW-1:0]),
    .rdata (ram_rdata)
  );

  // State, frame geometry and raster counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      col      <= '0;
      row      <= '0;
      width_q  <= '0;
      height_q <= '0;
    end else begin
      state    <= nxt_state;
      col      <= nxt_col;
      row      <= nxt_row;
      width_q  <= nxt_width;
      height_q <= nxt_height;
    end
  end

  // Next state, counter updates, RAM strobes and window trigger events.
  always_comb begin
    nxt_state   = state;
    nxt_col     = col;
    nxt_row     = row;
    nxt_width   = width_q;
    nxt_height  = height_q;
    pix_ready_o = 1'b0;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ev_emit     = 1'b0;
    ev_upd      = 1'b0;
    ev_edge     = 1'b0;
    ev_flush    = 1'b0;
    ev_last     = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          nxt_width  = img_width;
          nxt_height = img_height;
          nxt_col    = '0;
          nxt_row    = '0;
          nxt_state  = FILL;
        end
      end
      FILL: begin
        pix_ready_o = 1'b1;
        if (pix_valid_i) begin
          ram_we = 1'b1;
          if (col_last) begin
            nxt_col   = '0;
            nxt_row   = ROW_CNT_WIDTH'(1);
            nxt_state = RUN;
          end else begin
            nxt_col = col + COL_CNT_WIDTH'(1);
          end
        end
      end
      RUN: begin
        pix_ready_o = 1'b1;
        if (pix_valid_i) begin
          ram_we  = 1'b1;
          ram_re  = 1'b1;
          ev_upd  = 1'b1;
          ev_emit = (col != '0);
          if (col_last) begin
            nxt_col   = '0;
            nxt_state = EDGE;
          end else begin
            nxt_col = col + COL_CNT_WIDTH'(1);
          end
        end
      end
      EDGE: begin
        ev_emit = 1'b1;
        ev_edge = 1'b1;
        if (row_last) begin
          nxt_col   = '0;
          nxt_state = FLUSH;
        end else begin
          nxt_row   = row + ROW_CNT_WIDTH'(1);
          nxt_state = RUN;
        end
      end
      FLUSH: begin
        ram_re   = 1'b1;
        ev_upd   = 1'b1;
        ev_flush = 1'b1;
        ev_emit  = (col != '0);
        if (col_last) begin
          nxt_col   = '0;
          nxt_state = FEDGE;
        end else begin
          nxt_col = col + COL_CNT_WIDTH'(1);
        end
      end
      FEDGE: begin
        ev_emit   = 1'b1;
        ev_edge   = 1'b1;
        ev_last   = 1'b1;
        nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // In FLUSH the bottom row replicates the top row (both come from the RAM).
  assign bot_new = s1_flush ? ram_rdata : s1_pix;

  // Stage 1 holds the trigger; stage 2 forms the window from the previous column
  // (cur_*) and the new column (RAM read + registered pixel). Edge windows repeat cur_*.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe   <= '0;
      s1_upd     <= 1'b0;
      s1_edge    <= 1'b0;
      s1_flush   <= 1'b0;
      s1_last    <= 1'b0;
      s1_pix     <= '0;
      cur_top    <= '0;
      cur_bot    <= '0;
      buf00      <= '0;
      buf10      <= '0;
      buf01      <= '0;
      buf11      <= '0;
      frame_done <= 1'b0;
    end else begin
      vld_pipe   <= {vld_pipe[0], ev_emit};
      s1_upd     <= ev_upd;
      s1_edge    <= ev_edge;
      s1_flush   <= ev_flush;
      s1_last    <= ev_last;
      s1_pix     <= pix_i;
      frame_done <= vld_pipe[0] & s1_last;
      if (vld_pipe[0]) begin
        buf00 <= cur_top;
        buf01 <= cur_bot;
        buf10 <= s1_edge ? cur_top : ram_rdata;
        buf11 <= s1_edge ? cur_bot : bot_new;
      end
      if (s1_upd) begin
        cur_top <= ram_rdata;
        cur_bot <= bot_new;
      end
    end
  end

endmodule

// File: tb/tb_src_window_gen.sv
// Directed bench for src_window_gen: hand vectors plus an edge-replication model.
module tb_src_window_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [11:0] img_width;
  logic [11:0] img_height;
  logic [7:0]  pix_i;
  logic        pix_valid_i;
  logic        pix_ready_o;
  logic [7:0]  buf00, buf10, buf01, buf11;
  logic        calc_en, frame_done, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int stray  = 0;

  logic [32:0] win_q[$];   // {frame_done, buf00, buf10, buf01, buf11}
  int          wcyc_q[$];
  int          acc_q[$];
  logic [7:0]  px [0:3839];

  src_window_gen dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .img_width   (img_width),
    .img_height  (img_height),
    .pix_i       (pix_i),
    .pix_valid_i (pix_valid_i),
    .pix_ready_o (pix_ready_o),
    .buf00       (buf00),
    .buf10       (buf10),
    .buf01       (buf01),
    .buf11       (buf11),
    .calc_en     (calc_en),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log accepts and windows mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (pix_valid_i && pix_ready_o) acc_q.push_back(cyc);
    if (calc_en) begin
      win_q.push_back({frame_done, buf00, buf10, buf01, buf11});
      wcyc_q.push_back(cyc);
    end else if (frame_done) begin
      stray++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected window k of a WxH frame held in px[], raster order of top-left pixel.
  function automatic logic [32:0] model(input int w, input int h, input int k);
    int r, c, r1, c1;
    r  = k / w;
    c  = k % w;
    r1 = (r + 1 < h) ? r + 1 : h - 1;
    c1 = (c + 1 < w) ? c + 1 : w - 1;
    return {(k == w * h - 1), px[r*w+c], px[r*w+c1], px[r1*w+c], px[r1*w+c1]};
  endfunction

  task automatic start_frame(input int w, input int h);
    img_width   = 12'(w);
    img_height  = 12'(h);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  // Offer one pixel until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] p);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    pix_i       = p;
    pix_valid_i = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = pix_ready_o;
      @(posedge clk); #1;
      n++;
    end
    pix_valid_i = 1'b0;
    if (!acc) check("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_wins(input int target, input int budget);
    int n;
    n = 0;
    while (win_q.size() < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    idle(6);
    check("window_count", 64'(win_q.size()), 64'(target));
  endtask

  task automatic check_model(input string tag, input int base, input int w, input int h);
    for (int k = 0; k < w * h; k++)
      if (base + k < win_q.size()) check(tag, win_q[base+k], model(w, h, k));
  endtask

  int bw, ba;
  logic [32:0] s1_exp [4];

  initial begin
    s1_exp[0] = 33'h0_0A141E28;  // (10,20,30,40)
    s1_exp[1] = 33'h0_14142828;  // (20,20,40,40)
    s1_exp[2] = 33'h0_1E281E28;  // (30,40,30,40)
    s1_exp[3] = 33'h1_28282828;  // (40,40,40,40) + frame_done

    rst = 1'b1; frame_start = 1'b0; img_width = '0; img_height = '0;
    pix_i = '0; pix_valid_i = 1'b0;
    idle(3);
    check("rst_ready",   64'(pix_ready_o), 64'd0);
    check("rst_calc_en", 64'(calc_en),     64'd0);
    check("rst_busy",    64'(busy),        64'd0);
    check("rst_done",    64'(frame_done),  64'd0);
    check("rst_bufs",    64'({buf00, buf10, buf01, buf11}), 64'd0);
    rst = 1'b0;
    idle(1);

    // 2x2 frame: four hand-computed windows, 2-cycle latency.
    bw = win_q.size(); ba = acc_q.size();
    px[0] = 8'd10; px[1] = 8'd20; px[2] = 8'd30; px[3] = 8'd40;
    start_frame(2, 2);
    check("fill_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) send(px[i]);
    wait_wins(bw + 4, 100);
    for (int k = 0; k < 4; k++)
      if (bw + k < win_q.size()) check("s1_win", win_q[bw+k], s1_exp[k]);
    if (win_q.size() > bw && acc_q.size() > ba + 3)
      check("latency", 64'(wcyc_q[bw] - acc_q[ba+3]), 64'd2);
    check("s1_idle", 64'(busy), 64'd0);

    // 4x3 ramp, gap-free then with random gaps; EDGE bubble on ready.
    for (int i = 0; i < 12; i++) px[i] = 8'(i);
    bw = win_q.size();
    start_frame(4, 3);
    for (int i = 0; i < 12; i++) send(px[i]);
    wait_wins(bw + 12, 200);
    check_model("s2_nogap", bw, 4, 3);

    bw = win_q.size();
    start_frame(4, 3);
    for (int i = 0; i < 12; i++) begin
      send(px[i]);
      if (i == 7) begin
        check("edge_ready_low", 64'(pix_ready_o), 64'd0);
        idle(1);
        check("edge_ready_back", 64'(pix_ready_o), 64'd1);
      end
      if (i == 11) check("edge2_ready_low", 64'(pix_ready_o), 64'd0);
      idle($urandom_range(0, 3));
    end
    wait_wins(bw + 12, 200);
    check_model("s2_gap", bw, 4, 3);

    // Full-width frame: column 1919 must come back from linebuf[1919].
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 1920; c++) px[r*1920+c] = 8'((c * 3 + r * 101) & 255);
    bw = win_q.size();
    start_frame(1920, 2);
    for (int i = 0; i < 3840; i++) send(px[i]);
    wait_wins(bw + 3840, 4000);
    check_model("s3_wide", bw, 1920, 2);

    // Reset in RUN at row 1, col 2 discards the frame.
    for (int i = 0; i < 8; i++) px[i] = 8'(8'hA0 + i);
    start_frame(4, 2);
    for (int i = 0; i < 6; i++) send(px[i]);
    bw = win_q.size();
    rst = 1'b1;
    @(posedge clk); #1;
    check("s4_calc_en", 64'(calc_en),     64'd0);
    check("s4_ready",   64'(pix_ready_o), 64'd0);
    check("s4_busy",    64'(busy),        64'd0);
    rst = 1'b0;
    idle(4);
    check("s4_no_win", 64'(win_q.size()), 64'(bw));
    px[0] = 8'd10; px[1] = 8'd20; px[2] = 8'd30; px[3] = 8'd40;
    start_frame(2, 2);
    for (int i = 0; i < 4; i++) send(px[i]);
    wait_wins(bw + 4, 100);
    for (int k = 0; k < 4; k++)
      if (bw + k < win_q.size()) check("s4_win", win_q[bw+k], s1_exp[k]);

    // frame_start during FLUSH is ignored.
    for (int i = 0; i < 6; i++) px[i] = 8'(8'h50 + 8'(i * 7));
    bw = win_q.size();
    start_frame(3, 2);
    for (int i = 0; i < 6; i++) send(px[i]);
    idle(1);
    img_width   = 12'd8;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    wait_wins(bw + 6, 100);
    check_model("s5_win", bw, 3, 2);
    check("s5_idle", 64'(busy), 64'd0);

    check("stray_done", 64'(stray), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
